// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-bus access unit.
package mem_pkg;

  // Access type as carried down the pipeline (2'b11 also means byte).
  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_BYTE = 2'b10;

  // dbus transfer size encoding.
  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  // Natural alignment: word on 4 bytes, half on 2 bytes, byte always.
  function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [1:0] st);
    logic ok;
    case (st)
      ST_WORD: ok = (addr_lo == 2'b00);
      ST_HALF: ok = ~addr_lo[0];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_wstrobe_gen.sv
// Byte-lane strobe, replicated write data and transfer size for one access.
module mem_wstrobe_gen
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  strobe_type_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  strobe_o,
  output logic [31:0] data_o,
  output logic [2:0]  size_o
);

  logic [3:0] lanes;

  // Lane selection and data replication per access type; loads drive no strobes.
  always_comb begin
    lanes  = 4'b0000;
    data_o = wdata_i;
    size_o = SIZE_WORD;
    case (strobe_type_i)
      ST_WORD: begin
        lanes  = 4'b1111;
        data_o = wdata_i;
        size_o = SIZE_WORD;
      end
      ST_HALF: begin
        lanes  = 4'b0011 << {addr_lo_i[1], 1'b0};
        data_o = {2{wdata_i[15:0]}};
        size_o = SIZE_HALF;
      end
      default: begin
        lanes  = 4'b0001 << addr_lo_i;
        data_o = {4{wdata_i[7:0]}};
        size_o = SIZE_BYTE;
      end
    endcase
    strobe_o = write_i ? lanes : 4'b0000;
  end

endmodule

// File: rtl/mem_dbus_access.sv
// MEM-stage data-bus access unit: issues one dbus request per aligned
// load/store, stalls until the response, then holds the raw read word.
// Build option MEM_ALIGN_CHECK_EN: misaligned accesses raise adel/ades and
// are not issued; otherwise the address is forced to natural alignment.
module mem_dbus_access
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_strobe_type,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              advance,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        tail,
  output logic [1:0]        strobe_type_out,
  output logic              adel,
  output logic              ades
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        type_q;
  logic              write_q;
  logic [3:0]        strobe_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        size_q;
  logic [DATA_W-1:0] rdata_q;

  logic              aligned;
  logic [ADDR_W-1:0] addr_eff;
  logic              take;
  logic              resp_fire;
  logic [3:0]        gen_strobe;
  logic [31:0]       gen_data;
  logic [2:0]        gen_size;

`ifdef MEM_ALIGN_CHECK_EN
  // Misaligned requests are flagged and never reach the bus.
  always_comb begin
    aligned  = is_aligned(req_addr[1:0], req_strobe_type);
    addr_eff = req_addr;
    adel     = req_valid & ~aligned & ~req_write;
    ades     = req_valid & ~aligned & req_write;
  end
`else
  // Everything proceeds; the low address bits are forced to natural alignment.
  always_comb begin
    aligned  = 1'b1;
    addr_eff = req_addr;
    case (req_strobe_type)
      ST_WORD: addr_eff[1:0] = 2'b00;
      ST_HALF: addr_eff[0]   = 1'b0;
      default: addr_eff      = req_addr;
    endcase
    adel = 1'b0;
    ades = 1'b0;
  end
`endif

  assign take      = (state_q == IDLE) & req_valid & aligned;
  assign resp_fire = ((state_q == ADDR) & dresp_addr_ok & dresp_data_ok) |
                     ((state_q == DATA) & dresp_data_ok);

  mem_wstrobe_gen u_wstrobe_gen (
    .addr_lo_i     (addr_eff[1:0]),
    .strobe_type_i (req_strobe_type),
    .write_i       (req_write),
    .wdata_i       (req_wdata),
    .strobe_o      (gen_strobe),
    .data_o        (gen_data),
    .size_o        (gen_size)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; advance outside DONE and responses outside their state are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = ADDR;
      ADDR:    if (dresp_addr_ok) state_d = dresp_data_ok ? DONE : DATA;
      DATA:    if (dresp_data_ok) state_d = DONE;
      DONE:    if (advance) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus valid and pipeline stall.
  always_comb begin
    dreq_valid = (state_q == ADDR);
    busy       = req_valid & aligned & (state_q != DONE);
  end

  // Request fields are captured once on acceptance and held for the whole access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q   <= '0;
      type_q   <= '0;
      write_q  <= 1'b0;
      strobe_q <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
    end else if (take) begin
      addr_q   <= addr_eff;
      type_q   <= req_strobe_type;
      write_q  <= req_write;
      strobe_q <= gen_strobe;
      wdata_q  <= gen_data;
      size_q   <= gen_size;
    end
  end

  // Read word capture; stores leave the previous word in place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    rdata_q <= '0;
    else if (resp_fire && !write_q) rdata_q <= dresp_data;
  end

  assign dreq_addr       = addr_q;
  assign dreq_size       = size_q;
  assign dreq_strobe     = strobe_q;
  assign dreq_data       = wdata_q;
  assign rdata           = rdata_q;
  assign tail            = addr_q[1:0];
  assign strobe_type_out = type_q;

endmodule

// File: tb/tb_mem_dbus_access.sv
// Self-checking bench for mem_dbus_access: directed cases plus randomized
// transactions against a transaction-level reference model.
module tb_mem_dbus_access;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_strobe_type = '0;
  logic [31:0] req_wdata = '0;
  logic        advance = 1'b0;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = '0;
  logic        busy;
  logic [31:0] rdata;
  logic [1:0]  tail;
  logic [1:0]  strobe_type_out;
  logic        adel;
  logic        ades;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_rdata = '0;

  mem_dbus_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_strobe_type (req_strobe_type),
    .req_wdata       (req_wdata),
    .advance         (advance),
    .dreq_valid      (dreq_valid),
    .dreq_addr       (dreq_addr),
    .dreq_size       (dreq_size),
    .dreq_strobe     (dreq_strobe),
    .dreq_data       (dreq_data),
    .dresp_addr_ok   (dresp_addr_ok),
    .dresp_data_ok   (dresp_data_ok),
    .dresp_data      (dresp_data),
    .busy            (busy),
    .rdata           (rdata),
    .tail            (tail),
    .strobe_type_out (strobe_type_out),
    .adel            (adel),
    .ades            (ades)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_aligned(input bit [1:0] ty, input bit [31:0] a);
    if (ty == 2'd0) return (a % 4) == 0;
    if (ty == 2'd1) return (a % 2) == 0;
    return 1'b1;
  endfunction

  // One access from IDLE: responder answers addr_ok after d1 wait cycles and
  // data_ok d2 cycles after that (0 = together). Entered and left at a negedge.
  task automatic run_txn(input bit wr, input bit [1:0] ty, input bit [31:0] addr,
                         input bit [31:0] wd, input bit [31:0] rw,
                         input int d1, input int d2, input bit bad_adv);
    bit [31:0] ea;
    bit [31:0] es;
    bit [31:0] ed;
    bit [31:0] esz;
    int lane, busy_n, vcnt, dcnt, cyc;
    bit acc, done;
    ea = addr;
`ifndef MEM_ALIGN_CHECK_EN
    if (ty == 2'd0) ea = addr - (addr % 4);
    else if (ty == 2'd1) ea = addr - (addr % 2);
`endif
    lane = ea % 4;
    if (ty == 2'd0)      begin es = 15;          ed = wd;                     esz = 2; end
    else if (ty == 2'd1) begin es = 3 << lane;   ed = (wd % 65536) * 32'h00010001; esz = 1; end
    else                 begin es = 1 << lane;   ed = (wd % 256) * 32'h01010101;   esz = 0; end
    if (!wr) es = 0;

    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; advance = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_strobe_type = ty; req_wdata = wd;
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    if (!ref_aligned(ty, addr)) begin
      for (int k = 0; k < 3; k++) begin
        chk("mis_adel", adel, !wr);
        chk("mis_ades", ades, wr);
        chk("mis_busy", busy, 0);
        chk("mis_dv", dreq_valid, 0);
        @(negedge clk); #1;
      end
      req_valid = 1'b0;
      @(negedge clk);
      return;
    end
`endif
    chk("req_busy", busy, 1);
    chk("req_dv", dreq_valid, 0);
    chk("req_adel", adel, 0);
    chk("req_ades", ades, 0);
    busy_n = 1; vcnt = 0; dcnt = 0; acc = 0; done = 0;
    for (cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; advance = 1'b0; dresp_data = $urandom;
      #1;
      if (cyc == 0) chk("dv_rise", dreq_valid, 1);
      if (!busy) begin
        done = 1;
      end else begin
        busy_n++;
        if (dreq_valid) begin
          vcnt++;
          chk("f_addr", dreq_addr, ea);
          chk("f_size", dreq_size, esz);
          chk("f_strobe", dreq_strobe, es);
          if (wr) chk("f_data", dreq_data, ed);
          if (vcnt == d1 + 1) begin
            dresp_addr_ok = 1'b1; acc = 1;
            if (d2 == 0) begin dresp_data_ok = 1'b1; dresp_data = rw; end
          end
        end else if (acc) begin
          dcnt++;
          if (dcnt == d2) begin dresp_data_ok = 1'b1; dresp_data = rw; end
        end
        if (bad_adv) advance = 1'($urandom % 2);
      end
    end
    chk("timeout", done, 1);
    chk("busy_cycles", busy_n, 2 + d1 + d2);
    chk("dv_cycles", vcnt, d1 + 1);
    chk("done_dv", dreq_valid, 0);
    if (!wr) model_rdata = rw;
    chk("rdata", rdata, model_rdata);
    chk("tail", tail, ea % 4);
    chk("stype", strobe_type_out, ty);
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0; req_valid = 1'b0;
  endtask

  // Idle cycles with stray handshakes that must be ignored.
  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      req_valid = 1'b0;
      dresp_addr_ok = 1'($urandom % 2);
      dresp_data_ok = 1'($urandom % 2);
      dresp_data = $urandom;
      @(negedge clk);
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      #1;
      chk("gap_rdata", rdata, model_rdata);
      chk("gap_dv", dreq_valid, 0);
      chk("gap_busy", busy, 0);
    end
  endtask

  task automatic reset_mid_data();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0100;
    req_strobe_type = 2'd0; req_wdata = '0;
    @(negedge clk);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    #1;
    chk("rst_in_data_dv", dreq_valid, 0);
    chk("rst_in_data_busy", busy, 1);
    req_valid = 1'b0; resetn = 1'b0;
    #1;
    model_rdata = 0;
    chk("rst_rdata", rdata, 0);
    chk("rst_tail", tail, 0);
    chk("rst_addr", dreq_addr, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    resetn = 1'b1; dresp_data_ok = 1'b1; dresp_data = 32'h5555_AAAA;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    #1;
    chk("stray_rdata", rdata, 0);
    chk("stray_dv", dreq_valid, 0);
    chk("stray_stype", strobe_type_out, 0);
    @(negedge clk);
  endtask

  initial begin
    bit [1:0] ty;
    bit [31:0] a;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_busy0", busy, 0);
    chk("rst_dv0", dreq_valid, 0);
    chk("rst_rdata0", rdata, 0);
    chk("rst_tail0", tail, 0);
    chk("rst_stype0", strobe_type_out, 0);
    chk("rst_strobe0", dreq_strobe, 0);
    chk("rst_adel0", adel, 0);
    chk("rst_ades0", ades, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_txn(0, 2'd0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    run_txn(1, 2'd2, 32'h8000_0023, 32'h1234_56A5, 32'h1111_1111, 0, 0, 0);
    run_txn(0, 2'd1, 32'h8000_0102, 32'h0, 32'hCAFE_F00D, 3, 2, 0);
    run_txn(1, 2'd1, 32'h8000_0200, 32'h0000_BEEF, 32'h0, 0, 1, 0);
    run_txn(1, 2'd1, 32'h8000_0206, 32'h0000_1234, 32'h0, 1, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
    run_txn(0, 2'd0, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0);
`endif
    idle_gap(2);
    reset_mid_data();
    run_txn(0, 2'd3, 32'h0000_0041, 32'h0, 32'h7654_3210, 0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      ty = 2'($urandom % 4);
      a = $urandom;
      if (($urandom % 4) != 0) begin
        if (ty == 2'd0) a = a - (a % 4);
        else if (ty == 2'd1) a = a - (a % 2);
      end
      run_txn(1'($urandom % 2), ty, a, $urandom, $urandom,
              int'($urandom % 4), int'($urandom % 4), 1'($urandom % 2));
      if (($urandom % 3) == 0) idle_gap(int'($urandom_range(1, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
